// File: rtl/uart_rx_irq.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_irq
// Brief    : 8N1 UART receiver feeding a first-word-fall-through byte FIFO,
//            with sticky error flags and a level interrupt for the core.
//            Define UART_RX_PARITY_EN to receive 8E1 frames (adds PARITY_ERR).
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_irq #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          RX,
    input  logic                          IRQ_EN,
    input  logic                          RD_EN,
    input  logic                          ERR_CLR,
    output logic [7:0]                    RD_DATA,
    output logic                          EMPTY,
    output logic                          FULL,
    output logic [$clog2(FIFO_DEPTH):0]   COUNT,
    output logic                          FRAME_ERR,
    output logic                          OVERRUN,
`ifdef UART_RX_PARITY_EN
    output logic                          PARITY_ERR,
`endif
    output logic                          UART_INT
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] CNT_FULL  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif

    // ------------------------------------------------------------------
    // Input synchroniser (idles high so reset does not look like a start)
    // ------------------------------------------------------------------
    logic sync1_q;
    logic rx_s_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= RX;
            rx_s_q  <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [2:0]    bit_q,   bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          push_req;
    logic          frame_set;
`ifdef UART_RX_PARITY_EN
    logic          par_q, par_d;
    logic          parity_set;
    logic          parity_ok;

    assign parity_ok = ~^{shift_q, par_q};
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_d     = bit_q;
        shift_d   = shift_q;
        push_req  = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d      = par_q;
        parity_set = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    par_d   = rx_s_q;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d     = '0;
                    state_d   = S_IDLE;
                    frame_set = ~rx_s_q;
`ifdef UART_RX_PARITY_EN
                    parity_set = ~parity_ok;
                    push_req   = rx_s_q & parity_ok;
`else
                    push_req   = rx_s_q;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [7:0]  fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          empty_q,  empty_d;
    logic          full_q,   full_d;
    logic          do_pop;
    logic          do_push;
    logic          overrun_set;

    // A full FIFO still takes the byte when a pop frees a slot on the same edge.
    assign do_pop      = RD_EN & ~empty_q;
    assign do_push     = push_req & (~full_q | do_pop);
    assign overrun_set = push_req & full_q & ~do_pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
        empty_d = (count_d == '0);
        full_d  = (count_d == DEPTH_CNT);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) begin
            fifo_mem_q[wr_ptr_q] <= shift_q;
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags: a set on the same cycle as ERR_CLR wins
    // ------------------------------------------------------------------
    logic frame_err_q, frame_err_d;
    logic overrun_q,   overrun_d;
`ifdef UART_RX_PARITY_EN
    logic parity_err_q, parity_err_d;

    assign parity_err_d = (parity_err_q & ~ERR_CLR) | parity_set;
`endif

    assign frame_err_d = (frame_err_q & ~ERR_CLR) | frame_set;
    assign overrun_d   = (overrun_q   & ~ERR_CLR) | overrun_set;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign RD_DATA   = empty_q ? 8'h00 : fifo_mem_q[rd_ptr_q];
    assign EMPTY     = empty_q;
    assign FULL      = full_q;
    assign COUNT     = count_q;
    assign FRAME_ERR = frame_err_q;
    assign OVERRUN   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign PARITY_ERR = parity_err_q;
`endif
    assign UART_INT  = IRQ_EN & ~empty_q;

endmodule
`default_nettype wire

// File: doc/uart_rx_irq.md
Name: uart_rx_irq

Overview:
- UART receiver sitting directly upstream of the core top level; its UART_INT output drives the core's UART_INT (external interrupt) input.
- Deserialises 8N1 frames from the serial RX pin and buffers bytes in a FIFO.
- Exposes a pop interface for the memory-mapped I/O path, sticky error flags, and a level interrupt raised while buffered data exists.

Parameters:
- CLKS_PER_BIT, 868, CLK cycles per serial bit (100 MHz / 115200); legal range ≥ 4.
- FIFO_DEPTH, 16, receive FIFO entries; power of two, ≥ 2.

Ports:
- CLK  input  1  system clock; all logic on its rising edge.
- RESET  input  1  asynchronous, active-low reset.
- RX  input  1  serial line, asynchronous to CLK, idle high.
- IRQ_EN  input  1  interrupt enable.
- RD_EN  input  1  pop head of FIFO; ignored when EMPTY.
- ERR_CLR  input  1  clears FRAME_ERR and OVERRUN.
- RD_DATA  output  8  FIFO head, first-word-fall-through; 0 when EMPTY.
- EMPTY  output  1  FIFO holds no bytes.
- FULL  output  1  FIFO holds FIFO_DEPTH bytes.
- COUNT  output  $clog2(FIFO_DEPTH)+1  bytes held.
- FRAME_ERR  output  1  sticky: stop bit sampled low.
- OVERRUN  output  1  sticky: valid byte dropped because FIFO was full.
- UART_INT  output  1  interrupt to core: IRQ_EN & ~EMPTY.

Behaviour:
- Reset (RESET=0, asynchronous):
  - FSM returns to IDLE; bit and sample counters are 0; FIFO pointers and COUNT are 0.
  - EMPTY=1, FULL=0, RD_DATA=0, FRAME_ERR=0, OVERRUN=0, UART_INT=0.
  - Synchroniser flops reset to 1.
  - Asserting reset mid-frame discards the partial byte and all buffered bytes.
- Input sync: RX passes through 2 flops; rx_s denotes the second flop. All sampling uses rx_s, which lags RX by 2 cycles.
- FSM states: IDLE, START, DATA, STOP. A single counter cnt counts CLK cycles within the current bit.
  - IDLE: when rx_s==0, go to START with cnt=0.
  - START: when cnt==CLKS_PER_BIT/2-1, sample rx_s. If 0, go to DATA with cnt=0 and bit index=0. If 1, it was a glitch: return to IDLE, push nothing, flag nothing.
  - DATA: when cnt==CLKS_PER_BIT-1, sample rx_s into shift[bit index] (LSB first) and reset cnt. After bit 7, go to STOP.
  - STOP: when cnt==CLKS_PER_BIT-1, sample rx_s.
    - If 1: push the byte, then return to IDLE.
    - If 0: set FRAME_ERR and discard the byte. Return to IDLE; a line held low re-enters START.
- Push rule:
  - The push is accepted if COUNT<FIFO_DEPTH, or if a pop occurs in the same cycle (full + RD_EN → push and pop both happen, COUNT unchanged).
  - Otherwise the byte is dropped and OVERRUN is set.
- Pop rule: when RD_EN=1 and EMPTY=0, the read pointer advances at the clock edge and RD_DATA shows the next entry the following cycle.
- Simultaneous push and pop when EMPTY: the pop is ignored and the push is accepted.
- Pointers wrap modulo FIFO_DEPTH. COUNT, EMPTY and FULL are registered and consistent in every cycle.
- Sticky flags: ERR_CLR clears them. If a set event and ERR_CLR occur in the same cycle, the set wins.
- UART_INT is combinational from IRQ_EN and the registered EMPTY, so it has no glitch from the FSM. It is high from the cycle after the accepting push until the cycle after the pop that empties the FIFO.
- Latency: the byte appears on RD_DATA and EMPTY deasserts 1 cycle after the stop-bit sample cycle. From the RX stop-bit midpoint this is 3 cycles, including the synchroniser.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, sampled at CLKS_PER_BIT-1.
  - Even parity is checked over the 8 data bits plus the parity bit.
  - Mismatch sets sticky output PARITY_ERR (reset 0, cleared by ERR_CLR, set wins) and discards the byte.
  - Frame length becomes 11 bits.
- Undefined: no PARITY state, no PARITY_ERR port; 8N1 only.

Test Plan (CLKS_PER_BIT=16, FIFO_DEPTH=4):
- Send 0xA5 as an 8N1 frame with IRQ_EN=1:
  - EMPTY falls and UART_INT rises with RD_DATA=0xA5 and COUNT=1.
  - Pulse RD_EN → EMPTY=1, UART_INT=0 next cycle.
- Drive an 8-cycle RX low glitch → no push, no flags, FSM back in IDLE.
- Send 0x3C with the stop bit held low → FRAME_ERR=1, COUNT=0; ERR_CLR → FRAME_ERR=0.
- Send 5 bytes 0x01..0x05 without reads:
  - FULL=1, COUNT=4, OVERRUN=1.
  - Reads return 0x01..0x04.
  - With FULL and RD_EN asserted on the 5th stop sample instead, the push is accepted and COUNT stays 4.
- Pull RESET low in DATA state after 2 buffered bytes → EMPTY=1, COUNT=0, RD_DATA=0.
- Release RESET, then send 0x7E → 0x7E received correctly.
- With UART_RX_PARITY_EN: send 0x03 with parity bit 1 → PARITY_ERR=1, no push; send 0x03 with parity bit 0 → byte accepted.
